match_timer: RTL and testbench
==============================

// Module: match_timer
// PURPOSE
//   Parametrised up-counter/timer with programmable period and NUM_CMP compare channels.
//   Runs free (auto-reload) or one-shot; each channel emits a one-cycle match pulse.
//   Generalises the fixed 5-bit counter/match block; feeds PWM, scheduling and timeout logic.
// PARAMETERS
//   WIDTH    8   counter, period and compare width in bits (>=2)
//   NUM_CMP  2   number of compare channels (>=1)
// PORTS
//   clk       in   1              system clock, all logic on posedge
//   rst       in   1              synchronous, active-high reset
//   start     in   1              pulse: clear count to 0 and enter RUN
//   stop      in   1              pulse: halt, hold count, enter IDLE
//   mode      in   1              0 = continuous (auto-reload), 1 = one-shot
//   period    in   WIDTH          terminal count; sequence is 0..period
//   cmp_val   in   NUM_CMP*WIDTH  compare values; channel i = cmp_val[i*WIDTH +: WIDTH]
//   count     out  WIDTH          current count (registered)
//   match     out  NUM_CMP        per-channel one-cycle match pulse (registered)
//   wrap      out  1              one-cycle pulse when count reloads from period to 0
//   done      out  1              one-cycle pulse when a one-shot run completes
//   busy      out  1              high while state == RUN
// BEHAVIOUR
//   - Reset: state IDLE; count, match, wrap, done, busy = 0. Overrides all inputs.
//   - States: IDLE, RUN, DONE.
//     IDLE -start-> RUN. RUN -stop-> IDLE. RUN -terminal, mode=1-> DONE. DONE -start-> RUN.
//   - Priority each cycle: rst > stop > start > count step.
//     start in RUN restarts: count <= 0. start+stop same cycle: stop wins.
//   - tick = 1 every cycle (see CONFIGURATION). Count steps only in RUN on tick.
//   - Terminal: count >= period (>= so a period lowered mid-run below count
//     wraps on next tick). Terminal+tick: mode 0 -> count <= 0, wrap <= 1;
//     mode 1 -> count <= 0, done <= 1, state <= DONE. Else count <= count+1.
//   - period = 0: mode 0 holds count at 0, wrap pulses every tick;
//     mode 1 completes on the first tick after start.
//   - match[i] <= (RUN && tick && count == cmp_i): compares the pre-step value,
//     so pulse is high in the cycle after count == cmp_i (latency 1).
//     cmp_i > period never matches. Not asserted in IDLE/DONE or on the start cycle.
//   - count arithmetic is modulo 2^WIDTH; period = 2^WIDTH-1 gives the full range.
//   - IDLE holds count (stop freezes value); DONE holds 0. busy = (state == RUN).
//   - mode, period, cmp_val sampled live every cycle; no shadow registers.
// CONFIGURATION
//   MATCH_TIMER_PRESCALE_EN defined: adds input presc [7:0] and an internal
//     8-bit prescaler; tick = 1 once every presc+1 cycles in RUN. Prescaler
//     clears on rst, start and stop; first tick occurs presc+1 cycles after start.
//     wrap/done/match fire only on tick cycles.
//   Not defined: no presc port, no prescaler; tick = 1 every cycle.
// TESTING
//   1. rst high 3 cycles mid-run -> count=0, all pulses 0, busy=0, state IDLE.
//   2. mode=0, period=4, start -> count 0,1,2,3,4,0,1..; wrap high exactly when count
//      returns to 0, every 5 cycles.
//   3. mode=1, period=3, cmp0=2, cmp1=9 -> match[0] one pulse while count=3; match[1]
//      never; done pulse as count returns to 0; busy drops; count holds 0.
//   4. RUN at count=5: stop -> count holds 5, busy=0; start+stop same cycle -> stays IDLE;
//      start -> count=0, running.
//   5. period=200, count=150, period changed to 100 -> next tick count=0 with wrap pulse.
//   6. MATCH_TIMER_PRESCALE_EN, presc=2, period=2, mode=0 -> count steps every 3 cycles,
//      wrap every 9 cycles.

Source files
------------

// File: rtl/match_timer.sv
// match_timer: parametrised up-counter/timer with programmable period,
// continuous or one-shot operation and NUM_CMP compare channels, each of
// which emits a registered one-cycle match pulse.
// Optional feature: define MATCH_TIMER_PRESCALE_EN to add the presc input
// and an 8-bit prescaler that slows the count step to once every presc+1
// cycles.
module match_timer #(
    parameter int WIDTH   = 8,
    parameter int NUM_CMP = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     mode,
    input  logic [WIDTH-1:0]         period,
    input  logic [NUM_CMP*WIDTH-1:0] cmp_val,
`ifdef MATCH_TIMER_PRESCALE_EN
    input  logic [7:0]               presc,
`endif
    output logic [WIDTH-1:0]         count,
    output logic [NUM_CMP-1:0]       match,
    output logic                     wrap,
    output logic                     done,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     count_n;
    logic [NUM_CMP-1:0]   match_n;
    logic                 wrap_n;
    logic                 done_n;
    logic                 tick;

`ifdef MATCH_TIMER_PRESCALE_EN
    logic [7:0] presc_cnt;

    assign tick = (state == RUN) && (presc_cnt == presc);

    // Prescaler counts RUN cycles and restarts whenever the timer is (re)started or halted
    always_ff @(posedge clk) begin
        if (rst || start || stop) begin
            presc_cnt <= 8'd0;
        end else if (state == RUN) begin
            presc_cnt <= tick ? 8'd0 : presc_cnt + 8'd1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign busy = (state == RUN);

    // Next-state logic: stop beats start, start beats the normal count step
    always_comb begin
        state_n = state;
        count_n = count;
        match_n = '0;
        wrap_n  = 1'b0;
        done_n  = 1'b0;
        if (stop) begin
            state_n = IDLE;
        end else if (start) begin
            state_n = RUN;
            count_n = '0;
        end else if (state == RUN && tick) begin
            for (int i = 0; i < NUM_CMP; i++) begin
                match_n[i] = (count == cmp_val[i*WIDTH +: WIDTH]) &&
                             (cmp_val[i*WIDTH +: WIDTH] <= period);
            end
            if (count >= period) begin
                count_n = '0;
                if (mode) begin
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    wrap_n = 1'b1;
                end
            end else begin
                count_n = count + WIDTH'(1);
            end
        end
    end

    // State and output registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            match <= '0;
            wrap  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            match <= match_n;
            wrap  <= wrap_n;
            done  <= done_n;
        end
    end

endmodule

// File: tb/tb_match_timer.sv
// tb_match_timer: table-driven, scoreboard-checked bench for match_timer
// (WIDTH=8, NUM_CMP=2). Prescaler cases run when MATCH_TIMER_PRESCALE_EN is defined.
module tb_match_timer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        mode;
    logic [7:0]  period;
    logic [15:0] cmp_val;
`ifdef MATCH_TIMER_PRESCALE_EN
    logic [7:0]  presc;
`endif
    logic [7:0]  count;
    logic [1:0]  match;
    logic        wrap;
    logic        done;
    logic        busy;

    int num_checks = 0;
    int num_fail   = 0;

    typedef struct {
        logic       rst, start, stop, mode;
        logic [7:0] period, cmp0, cmp1;
        logic [7:0] e_count;
        logic [1:0] e_match;
        logic       e_wrap, e_done, e_busy;
    } vec_t;

    typedef struct {
        logic [7:0] count;
        logic [1:0] match;
        logic       wrap, done, busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    match_timer #(.WIDTH(8), .NUM_CMP(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .period  (period),
        .cmp_val (cmp_val),
`ifdef MATCH_TIMER_PRESCALE_EN
        .presc   (presc),
`endif
        .count   (count),
        .match   (match),
        .wrap    (wrap),
        .done    (done),
        .busy    (busy)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, s, p, m, input logic [7:0] per, c0, c1,
                                input logic [7:0] ec, input logic [1:0] em,
                                input logic ew, ed, eb);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.mode = m;
        v.period = per; v.cmp0 = c0; v.cmp1 = c1;
        v.e_count = ec; v.e_match = em; v.e_wrap = ew; v.e_done = ed; v.e_busy = eb;
        return v;
    endfunction

    task automatic check1(input string name, input int act, input int req);
        num_checks++;
        if (act != req) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Pop the oldest expectation and compare it against the registered outputs
    task automatic checkOutput(input string tag);
        exp_t e;
        num_checks++;
        if (sb.size() == 0) begin
            num_fail++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        num_checks--;
        e = sb.pop_front();
        check1({tag, " count"}, int'(count), int'(e.count));
        check1({tag, " match"}, int'(match), int'(e.match));
        check1({tag, " wrap"},  int'(wrap),  int'(e.wrap));
        check1({tag, " done"},  int'(done),  int'(e.done));
        check1({tag, " busy"},  int'(busy),  int'(e.busy));
    endtask

    // Drive one cycle of inputs, queue its expected result, then check after the edge
    task automatic applyStimulus(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        rst = v.rst; start = v.start; stop = v.stop; mode = v.mode;
        period = v.period; cmp_val = {v.cmp1, v.cmp0};
        e.count = v.e_count; e.match = v.e_match;
        e.wrap = v.e_wrap; e.done = v.e_done; e.busy = v.e_busy;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        period = 8'd0; cmp_val = 16'd0;
`ifdef MATCH_TIMER_PRESCALE_EN
        presc = 8'd0;
`endif

        // Reset, then continuous mode period 4 with cmp0=1, cmp1=4
        vecs.push_back(mk(1,1,0,0, 4,1,4,  0,2'b00,0,0,0));
        vecs.push_back(mk(0,1,0,0, 4,1,4,  0,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  1,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  2,2'b01,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  3,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  4,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  0,2'b10,1,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  1,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  2,2'b01,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  3,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  4,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 4,1,4,  0,2'b10,1,0,1));
        // One-shot period 3, cmp0=2, cmp1=9 (beyond period)
        vecs.push_back(mk(0,1,0,1, 3,2,9,  0,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,1, 3,2,9,  1,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,1, 3,2,9,  2,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,1, 3,2,9,  3,2'b01,0,0,1));
        vecs.push_back(mk(0,0,0,1, 3,2,9,  0,2'b00,0,1,0));
        vecs.push_back(mk(0,0,0,1, 3,2,9,  0,2'b00,0,0,0));
        vecs.push_back(mk(0,0,0,1, 3,2,9,  0,2'b00,0,0,0));
        // Stop / start+stop / restart
        vecs.push_back(mk(0,1,0,0, 9,2,9,  0,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 9,2,9,  1,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 9,2,9,  2,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 9,2,9,  3,2'b01,0,0,1));
        vecs.push_back(mk(0,0,0,0, 9,2,9,  4,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 9,2,9,  5,2'b00,0,0,1));
        vecs.push_back(mk(0,0,1,0, 9,2,9,  5,2'b00,0,0,0));
        vecs.push_back(mk(0,0,0,0, 9,2,9,  5,2'b00,0,0,0));
        vecs.push_back(mk(0,1,1,0, 9,2,9,  5,2'b00,0,0,0));
        vecs.push_back(mk(0,1,0,0, 9,2,9,  0,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 9,2,9,  1,2'b00,0,0,1));
        vecs.push_back(mk(0,0,1,0, 9,2,9,  1,2'b00,0,0,0));
        // Period 0: continuous wraps every cycle, one-shot completes on first tick
        vecs.push_back(mk(0,1,0,0, 0,0,9,  0,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,0, 0,0,9,  0,2'b01,1,0,1));
        vecs.push_back(mk(0,0,0,0, 0,0,9,  0,2'b01,1,0,1));
        vecs.push_back(mk(0,1,0,1, 0,0,9,  0,2'b00,0,0,1));
        vecs.push_back(mk(0,0,0,1, 0,0,9,  0,2'b01,0,1,0));
        vecs.push_back(mk(0,0,0,1, 0,0,9,  0,2'b00,0,0,0));

        foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Reset held 3 cycles in the middle of a run
        applyStimulus(mk(0,1,0,0, 50,3,7, 0,2'b00,0,0,1), "rst_run0");
        for (int k = 1; k <= 4; k++)
            applyStimulus(mk(0,0,0,0, 50,3,7, 8'(k),(k == 4) ? 2'b01 : 2'b00,0,0,1),
                          $sformatf("rst_run%0d", k));
        for (int k = 0; k < 3; k++)
            applyStimulus(mk(1,0,0,0, 50,3,7, 0,2'b00,0,0,0), $sformatf("rst_hold%0d", k));
        applyStimulus(mk(0,0,0,0, 50,3,7, 0,2'b00,0,0,0), "rst_after");

        // Period lowered below the running count forces a wrap on the next tick
        applyStimulus(mk(0,1,0,0, 200,250,251, 0,2'b00,0,0,1), "plow_start");
        for (int k = 1; k <= 150; k++)
            applyStimulus(mk(0,0,0,0, 200,250,251, 8'(k),2'b00,0,0,1), $sformatf("plow%0d", k));
        applyStimulus(mk(0,0,0,0, 100,250,251, 0,2'b00,1,0,1), "plow_wrap");
        applyStimulus(mk(0,0,0,0, 100,250,251, 1,2'b00,0,0,1), "plow_next");

        // Full range: period 255, cmp0=255, cmp1=0
        applyStimulus(mk(0,1,0,0, 255,255,0, 0,2'b00,0,0,1), "full_start");
        for (int k = 1; k <= 255; k++)
            applyStimulus(mk(0,0,0,0, 255,255,0, 8'(k),(k == 1) ? 2'b10 : 2'b00,0,0,1),
                          $sformatf("full%0d", k));
        applyStimulus(mk(0,0,0,0, 255,255,0, 0,2'b01,1,0,1), "full_wrap");

`ifdef MATCH_TIMER_PRESCALE_EN
        // Prescaler 2, period 2: count steps every 3 cycles, wrap every 9
        applyStimulus(mk(0,0,1,0, 2,9,9, count,2'b00,0,0,0), "presc_stop");
        presc = 8'd2;
        applyStimulus(mk(0,1,0,0, 2,9,9, 0,2'b00,0,0,1), "presc_start");
        for (int c = 1; c <= 18; c++)
            applyStimulus(mk(0,0,0,0, 2,9,9, 8'((c / 3) % 3), 2'b00,
                             (c % 3 == 0) && ((c / 3) % 3 == 0), 0, 1),
                          $sformatf("presc%0d", c));
`endif

        check1("scoreboard drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
